// File: rtl/cp0_int_if.sv
// CPU-side bus between the pipeline and the CP0 interrupt block.
// The CPU drives writes, event strobes and device IRQs; CP0 returns read data and control.
interface cp0_int_if;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] pc;
    logic [5:0]  hw_int;
    logic        exl_set;
    logic        exl_clr;
    logic [31:0] dout;
    logic [31:0] epc_out;
    logic        int_req;

    modport master (
        output we, addr, din, pc, hw_int, exl_set, exl_clr,
        input  dout, epc_out, int_req
    );

    modport slave (
        input  we, addr, din, pc, hw_int, exl_set, exl_clr,
        output dout, epc_out, int_req
    );
endinterface

// File: rtl/cp0_int.sv
// Coprocessor-0 interrupt controller: SR/Cause/EPC/PRId registers, IRQ masking,
// interrupt entry (EPC capture, EXL set) and eret.
module cp0_int #(
    parameter logic [31:0] PRID    = 32'h0000_4D49,
    parameter int unsigned NUM_INT = 6
) (
    input logic       clk,
    input logic       rst,
    cp0_int_if.slave  bus
);
    localparam logic [4:0] AddrSr    = 5'd12;
    localparam logic [4:0] AddrCause = 5'd13;
    localparam logic [4:0] AddrEpc   = 5'd14;
    localparam logic [4:0] AddrPrid  = 5'd15;

    logic [NUM_INT-1:0] im_q, im_d;
    logic [NUM_INT-1:0] ip_q;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic [31:2]        epc_q, epc_d;

    logic [31:0] sr_val, cause_val, epc_val;

    // Priority: exl_set over exl_clr over mtc0, applied by ordering the overrides.
    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        epc_d = epc_q;
        if (bus.we && bus.addr == AddrSr) begin
            im_d  = bus.din[15:10];
            exl_d = bus.din[1];
            ie_d  = bus.din[0];
        end
        if (bus.we && bus.addr == AddrEpc) begin
            epc_d = bus.din[31:2];
        end
        if (bus.exl_clr) begin
            exl_d = 1'b0;
        end
        if (bus.exl_set) begin
            exl_d = 1'b1;
            epc_d = bus.pc[31:2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q  <= '0;
            ip_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            ip_q  <= bus.hw_int;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            epc_q <= epc_d;
        end
    end

    // ExcCode is only ever written with zero, so it reads as constant zero.
    assign sr_val    = {16'h0, im_q, 8'h0, exl_q, ie_q};
    assign cause_val = {16'h0, ip_q, 10'h0};
    assign epc_val   = {epc_q, 2'b00};

    always_comb begin
        case (bus.addr)
            AddrSr:    bus.dout = sr_val;
            AddrCause: bus.dout = cause_val;
            AddrEpc:   bus.dout = epc_val;
            AddrPrid:  bus.dout = PRID;
            default:   bus.dout = 32'h0;
        endcase
    end

    assign bus.epc_out = epc_val;
    // Uses live hw_int so a device IRQ reaches the CPU with no register delay.
    assign bus.int_req = (|(bus.hw_int & im_q)) & ie_q & ~exl_q;
endmodule

// File: doc/cp0_int.md
Name: cp0_int

Overview:
- Coprocessor-0 style interrupt controller on the CPU side of the peripheral IRQ lines.
- Consumes the timer/counter IRQ outputs and other device IRQs on hw_int.
- Masks and qualifies them, and signals the CPU to take an interrupt.
- On interrupt entry, captures the return PC. Provides the SR/Cause/EPC/PRId registers for mfc0/mtc0 and restores state on eret.

Parameters:
PRID, 32'h0000_4D49, read-only processor ID value returned at register 15.
NUM_INT, 6, number of hardware interrupt lines; fixed at 6, maps to bits [15:10].

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
we  in  1  mtc0 write enable
addr  in  5  CP0 register number for read and write
din  in  32  mtc0 write data
pc  in  32  PC of the instruction to resume after interrupt entry
hw_int  in  6  level-sensitive device IRQs; bit 0 = timer 0, bit 1 = timer 1
exl_set  in  1  CPU is taking the interrupt this cycle
exl_clr  in  1  eret retiring this cycle
dout  out  32  mfc0 read data (combinational)
epc_out  out  32  current EPC, eret target
int_req  out  1  interrupt request to CPU (combinational)

Behaviour:
- Reset, asynchronous on posedge rst:
  - SR = 0, Cause = 0, EPC = 0.
  - Hence int_req = 0, epc_out = 0, and dout = 0 for addr 12, 13 and 14.
- SR, register 12:
  - Implemented bits: IM[15:10], EXL[1], IE[0]. All other bits read 0.
- Cause, register 13, read-only:
  - IP[15:10] <= hw_int every cycle (1-cycle registered copy).
  - ExcCode[6:2] is written to 0 on interrupt entry.
  - All other bits read 0.
- EPC, register 14:
  - 32-bit. Bits [1:0] are always 0 (forced on every write path).
- PRId, register 15:
  - Constant PRID. Writes are ignored.
- int_req = (|(hw_int & SR.IM)) & SR.IE & ~SR.EXL.
  - Computed combinationally from the live hw_int lines, not from Cause.IP, so there is zero added latency from a device IRQ.
- Interrupt entry (exl_set = 1 at the clock edge):
  - EPC <= {pc[31:2], 2'b00}.
  - SR.EXL <= 1.
  - Cause.ExcCode <= 0.
  - int_req drops the following cycle because EXL is set.
  - The CPU asserts exl_set only while int_req = 1. If exl_set is asserted without int_req, the block still performs entry.
- eret (exl_clr = 1 at the clock edge):
  - SR.EXL <= 0.
  - EPC is unchanged.
- mtc0 (we = 1):
  - addr 12 writes IM, EXL, IE from din[15:10], din[1], din[0].
  - addr 14 writes EPC from {din[31:2], 2'b00}.
  - addr 13, addr 15 and all other addresses are ignored.
- Simultaneous-event priority, highest first:
  1. exl_set
  2. exl_clr
  3. mtc0
- Simultaneous-event cases:
  - exl_set with we to addr 14: EPC takes pc; the din write is dropped.
  - exl_set with we to addr 12: EXL = 1 wins; the IM and IE fields from din still apply.
  - exl_set with exl_clr: EXL = 1.
  - exl_clr with we to addr 12: EXL = 0; IM and IE come from din.
- Reads:
  - dout is a combinational mux on addr: 12 → SR, 13 → Cause, 14 → EPC, 15 → PRId, else 32'h0.
  - dout reflects pre-edge values; a write is visible on the cycle after the edge.
- epc_out is EPC, continuously.
- hw_int is level-sensitive; the device clears its IRQ.
  - If a device IRQ is still high after eret with IE = 1 and the mask set, int_req reasserts the cycle after EXL clears.
- Reset mid-operation: all state clears immediately (asynchronously), regardless of exl_set, exl_clr or we.

Test Plan:
1. Reset then read → assert rst. Read addr 12, 13, 14, 15 → 0, 0, 0, PRID. int_req = 0 with hw_int = 6'h3F.
2. Masking → mtc0 SR = 32'h0000_0401 (IM bit 10, IE), hw_int = 6'b000010 → int_req = 0. Set hw_int = 6'b000001 → int_req = 1 the same cycle. Next cycle Cause reads 32'h0000_0400.
3. Entry and eret → with int_req = 1, pulse exl_set with pc = 32'h0000_3014.
   - After the edge: EPC = 32'h0000_3014, epc_out matches, SR reads 32'h0000_0403, int_req = 0.
   - Pulse exl_clr with hw_int still 1 → SR = 32'h0000_0401, int_req = 1.
4. Priority → in the same cycle assert exl_set with pc = 32'h0000_3100 and we to addr 14 with din = 32'h0000_5000 → EPC = 32'h0000_3100.
   - Separately, exl_set together with exl_clr → EXL = 1.
5. EPC alignment and read-only registers → mtc0 addr 14 with din = 32'h0000_3003 → EPC = 32'h0000_3000.
   - mtc0 addr 13 and addr 15 with 32'hFFFF_FFFF → both unchanged.
6. Asynchronous reset mid-interrupt → while EXL = 1 and EPC is nonzero, raise rst between clock edges → SR, EPC and epc_out become 0 before the next edge.
